// File: rtl/cpu_id_scoreboard_pkg.sv
// Shared types and defaults for the decode-stage hazard scoreboard.
// Pure definitions, no logic; zero latency.
// No flow control of its own; consumers decide stall behaviour.
package cpu_id_scoreboard_pkg;

    localparam int NUM_GPR          = 32;
    localparam int DEF_NUM_RD_PORTS = 2;
    localparam int DEF_MAX_LAT      = 3;
    localparam int DEF_MAX_LONG     = 2;

    typedef logic [4:0] reg_addr_t;

    // True when register number a names GPR r.
    function automatic logic addr_is(input reg_addr_t a, input int unsigned r);
        return a == reg_addr_t'(r);
    endfunction

endpackage

// File: rtl/cpu_sb_entry.sv
// One GPR's hazard state: fixed-latency countdown plus outstanding long-op flag.
// State updates one cycle after the set/clear inputs; outputs are straight from flops.
// No backpressure; the parent only drives set inputs for instructions that actually leave ID.
module cpu_sb_entry #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             set_cnt,
    input  logic [CNT_W-1:0] set_val,
    input  logic             set_long,
    input  logic             clr_long,
    output logic             cnt_nz,
    output logic             long_q
);

    logic [CNT_W-1:0] cnt;

    // Countdown: flush beats a new write, a new write overwrites a live count, else decrement.
    // Long flag: a new long issue beats a same-cycle completion so the younger op stays tracked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            long_q <= 1'b0;
        end else begin
            if (flush) begin
                cnt <= '0;
            end else if (set_cnt) begin
                cnt <= set_val;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            if (set_long) begin
                long_q <= 1'b1;
            end else if (clr_long) begin
                long_q <= 1'b0;
            end
        end
    end

    assign cnt_nz = (cnt != '0);

endmodule

// File: rtl/cpu_id_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight GPR writes and requests an ID stall.
// stall_req/src_pending/issue_fire are combinational from flops and current inputs.
// Holds ID (stall_req) on unforwardable sources, WAW against a long op, or a full long-op table.
module cpu_id_scoreboard
    import cpu_id_scoreboard_pkg::*;
#(
    parameter int NUM_RD_PORTS = DEF_NUM_RD_PORTS,
    parameter int MAX_LAT      = DEF_MAX_LAT,
    parameter int MAX_LONG     = DEF_MAX_LONG,
    parameter int LAT_W        = $clog2(MAX_LAT + 2),
    parameter int LC_W         = $clog2(MAX_LONG + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  reg_addr_t [NUM_RD_PORTS-1:0]       src_raddr,
    input  logic      [NUM_RD_PORTS-1:0]       src_used,
    input  logic                               issue_valid,
    input  logic                               issue_we,
    input  reg_addr_t                          issue_waddr,
    input  logic      [LAT_W-1:0]              issue_lat,
    input  logic                               complete_valid,
    input  reg_addr_t                          complete_waddr,
    input  logic                               flush,
    output logic                               stall_req,
    output logic                               issue_fire,
    output logic      [NUM_RD_PORTS-1:0]       src_pending,
    output logic      [LC_W-1:0]               long_cnt
);

    localparam int               CNT_W    = $clog2(MAX_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LONG = '1;

    logic [NUM_GPR-1:0] cnt_nz;
    logic [NUM_GPR-1:0] long_q;
    logic [NUM_GPR-1:0] pend;

    logic             issue_is_long;
    logic             issue_is_fixed;
    logic             issue_rec;
    logic [CNT_W-1:0] issue_cnt;
    logic             waw_stall;
    logic             long_full;
    logic             long_inc;
    logic             long_dec;

    assign issue_is_long  = (issue_lat == LAT_LONG);
    assign issue_is_fixed = (issue_lat != '0) && !issue_is_long;
    // Only a real GPR write that leaves ID outside a flush cycle changes state.
    assign issue_rec      = issue_fire && issue_we && (issue_waddr != '0) && !flush;
    assign issue_cnt      = (issue_lat > LAT_W'(MAX_LAT)) ? CNT_W'(MAX_LAT) : CNT_W'(issue_lat);

    // $0 has no entry and is never pending.
    assign cnt_nz[0] = 1'b0;
    assign long_q[0] = 1'b0;

    for (genvar r = 1; r < NUM_GPR; r++) begin : g_entry
        cpu_sb_entry #(
            .CNT_W (CNT_W)
        ) u_entry (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .set_cnt  (issue_rec && issue_is_fixed && addr_is(issue_waddr, r)),
            .set_val  (issue_cnt),
            .set_long (issue_rec && issue_is_long && addr_is(issue_waddr, r)),
            .clr_long (complete_valid && addr_is(complete_waddr, r)),
            .cnt_nz   (cnt_nz[r]),
            .long_q   (long_q[r])
        );
    end

    // Per-register pending: a completing long op is already forwardable from writeback.
    always_comb begin
        pend = '0;
        for (int r = 1; r < NUM_GPR; r++) begin
            pend[r] = cnt_nz[r] | (long_q[r] & ~(complete_valid & addr_is(complete_waddr, r)));
        end
    end

    // Source operand hazards.
    always_comb begin
        src_pending = '0;
        for (int i = 0; i < NUM_RD_PORTS; i++) begin
            src_pending[i] = src_used[i] & pend[src_raddr[i]];
        end
    end

    assign waw_stall  = issue_valid && issue_we && pend[issue_waddr] && long_q[issue_waddr];
    assign long_full  = issue_valid && issue_is_long && (long_cnt == LC_W'(MAX_LONG)) && !complete_valid;
    assign stall_req  = (|src_pending) || waw_stall || long_full;
    assign issue_fire = issue_valid && !stall_req;

    assign long_inc = issue_rec && issue_is_long;
    assign long_dec = complete_valid && long_q[complete_waddr];

    // Outstanding long-op count; simultaneous issue and completion cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            long_cnt <= '0;
        end else begin
            case ({long_inc, long_dec})
                2'b10:   long_cnt <= long_cnt + 1'b1;
                2'b01:   long_cnt <= long_cnt - 1'b1;
                default: long_cnt <= long_cnt;
            endcase
        end
    end

    // A completion must target a register with an outstanding long op.
    always_ff @(posedge clk) begin
        if (!rst && complete_valid) begin
            assert (long_q[complete_waddr])
            else $error("cpu_id_scoreboard: completion for r%0d with no outstanding long op", complete_waddr);
        end
    end

endmodule

// File: tb/tb_cpu_id_scoreboard.sv
// Directed bench for cpu_id_scoreboard with an expected-result queue.
// Each step checks combinational outputs mid-low-phase, before the next rising edge.
// Inputs change on the falling edge only, except for the asynchronous reset probe.
module tb_cpu_id_scoreboard;

    logic            clk;
    logic            rst;
    logic [1:0][4:0] src_raddr;
    logic [1:0]      src_used;
    logic            issue_valid;
    logic            issue_we;
    logic [4:0]      issue_waddr;
    logic [2:0]      issue_lat;
    logic            complete_valid;
    logic [4:0]      complete_waddr;
    logic            flush;
    logic            stall_req;
    logic            issue_fire;
    logic [1:0]      src_pending;
    logic [1:0]      long_cnt;

    localparam logic [2:0] LONG = 3'b111;

    cpu_id_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .src_raddr      (src_raddr),
        .src_used       (src_used),
        .issue_valid    (issue_valid),
        .issue_we       (issue_we),
        .issue_waddr    (issue_waddr),
        .issue_lat      (issue_lat),
        .complete_valid (complete_valid),
        .complete_waddr (complete_waddr),
        .flush          (flush),
        .stall_req      (stall_req),
        .issue_fire     (issue_fire),
        .src_pending    (src_pending),
        .long_cnt       (long_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [5:0] val;   // {stall_req, issue_fire, src_pending[1:0], long_cnt[1:0]}
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push_exp(input string tag, input logic stall, input logic fire,
                            input logic [1:0] pend, input logic [1:0] lc);
        exp_t e;
        e.tag = tag;
        e.val = {stall, fire, pend, lc};
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t       e;
        logic [5:0] obs;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_underflow: observed empty queue, expected an entry");
        end else begin
            e   = sb.pop_front();
            obs = {stall_req, issue_fire, src_pending, long_cnt};
            checks++;
            assert (obs === e.val)
            else begin
                errors++;
                $error("FAIL %s: observed stall=%b fire=%b pend=%b lcnt=%0d expected stall=%b fire=%b pend=%b lcnt=%0d",
                       e.tag, obs[5], obs[4], obs[3:2], obs[1:0], e.val[5], e.val[4], e.val[3:2], e.val[1:0]);
            end
        end
    endtask

    // Queue the expected outputs for the inputs currently driven, compare, then advance one cycle.
    task automatic step(input string tag, input logic stall, input logic fire,
                        input logic [1:0] pend, input logic [1:0] lc);
        push_exp(tag, stall, fire, pend, lc);
        #2;
        pop_check();
        @(negedge clk);
    endtask

    task automatic idle_in();
        src_raddr      = '0;
        src_used       = '0;
        issue_valid    = 1'b0;
        issue_we       = 1'b0;
        issue_waddr    = '0;
        issue_lat      = '0;
        complete_valid = 1'b0;
        complete_waddr = '0;
        flush          = 1'b0;
    endtask

    task automatic set_issue(input logic v, input logic we, input logic [4:0] wa, input logic [2:0] lat);
        issue_valid = v;
        issue_we    = we;
        issue_waddr = wa;
        issue_lat   = lat;
    endtask

    task automatic set_src(input logic [4:0] a0, input logic u0, input logic [4:0] a1, input logic u1);
        src_raddr[0] = a0;
        src_used[0]  = u0;
        src_raddr[1] = a1;
        src_used[1]  = u1;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        step("reset_state", 0, 0, 2'b00, 2'd0);
        rst = 1'b0;

        // Load-use: one bubble for a latency-1 producer.
        set_issue(1, 1, 5'd5, 3'd1);
        step("t1_issue_lat1", 0, 1, 2'b00, 2'd0);
        set_issue(1, 1, 5'd6, 3'd0);
        set_src(5'd5, 1, 5'd0, 0);
        step("t1_load_use_stall", 1, 0, 2'b01, 2'd0);
        step("t1_load_use_release", 0, 1, 2'b00, 2'd0);

        // Latency-3 producer: three stall cycles; $0 on the other port never blocks.
        idle_in();
        set_issue(1, 1, 5'd8, 3'd3);
        step("t2_issue_lat3", 0, 1, 2'b00, 2'd0);
        set_issue(1, 0, 5'd10, 3'd0);
        set_src(5'd0, 1, 5'd8, 1);
        step("t2_stall_c1", 1, 0, 2'b10, 2'd0);
        step("t2_stall_c2", 1, 0, 2'b10, 2'd0);
        step("t2_stall_c3", 1, 0, 2'b10, 2'd0);
        step("t2_release", 0, 1, 2'b00, 2'd0);
        idle_in();
        set_issue(1, 1, 5'd8, 3'd3);
        step("t2_reissue_lat3", 0, 1, 2'b00, 2'd0);
        set_issue(1, 0, 5'd10, 3'd0);
        set_src(5'd0, 1, 5'd8, 0);
        step("t2_unused_src_no_stall", 0, 1, 2'b00, 2'd0);

        // Long op: stall until completion, released in the completion cycle.
        idle_in();
        set_issue(1, 1, 5'd9, LONG);
        step("t3_issue_long", 0, 1, 2'b00, 2'd0);
        idle_in();
        set_src(5'd9, 1, 5'd0, 0);
        step("t3_long_wait1", 1, 0, 2'b01, 2'd1);
        step("t3_long_wait2", 1, 0, 2'b01, 2'd1);
        set_issue(1, 0, 5'd0, 3'd0);
        complete_valid = 1'b1;
        complete_waddr = 5'd9;
        step("t3_complete_bypass", 0, 1, 2'b00, 2'd1);
        idle_in();
        step("t3_long_cnt_drained", 0, 0, 2'b00, 2'd0);

        // Long-op table saturation.
        set_issue(1, 1, 5'd9, LONG);
        step("t4_long_a", 0, 1, 2'b00, 2'd0);
        set_issue(1, 1, 5'd10, LONG);
        step("t4_long_b", 0, 1, 2'b00, 2'd1);
        set_issue(1, 1, 5'd11, LONG);
        step("t4_long_full_stall", 1, 0, 2'b00, 2'd2);
        complete_valid = 1'b1;
        complete_waddr = 5'd10;
        step("t4_full_with_complete", 0, 1, 2'b00, 2'd2);
        idle_in();
        set_issue(1, 1, 5'd9, 3'd1);
        step("t4_waw_vs_long", 1, 0, 2'b00, 2'd2);

        // Flush clears fixed-latency state only; completion in the flush cycle still counts.
        idle_in();
        set_issue(1, 1, 5'd4, 3'd3);
        step("t5_issue_lat3", 0, 1, 2'b00, 2'd2);
        set_issue(1, 1, 5'd12, 3'd2);
        flush          = 1'b1;
        complete_valid = 1'b1;
        complete_waddr = 5'd11;
        step("t5_flush_cycle", 0, 1, 2'b00, 2'd2);
        idle_in();
        set_issue(1, 0, 5'd0, 3'd0);
        set_src(5'd4, 1, 5'd9, 1);
        step("t5_flushed_vs_long", 1, 0, 2'b10, 2'd1);
        set_src(5'd12, 1, 5'd11, 1);
        step("t5_ignored_and_completed", 0, 1, 2'b00, 2'd1);

        // Asynchronous reset in the middle of a countdown.
        idle_in();
        set_issue(1, 1, 5'd4, 3'd3);
        step("t6_issue_lat3", 0, 1, 2'b00, 2'd1);
        set_issue(0, 0, 5'd0, 3'd0);
        set_src(5'd4, 1, 5'd9, 1);
        step("t6_cnt3", 1, 0, 2'b11, 2'd1);
        push_exp("t6_cnt2", 1, 0, 2'b11, 2'd1);
        #2;
        pop_check();
        #1;
        rst = 1'b1;
        #1;
        push_exp("t6_async_reset", 0, 0, 2'b00, 2'd0);
        pop_check();
        @(negedge clk);
        step("t6_reset_held", 0, 0, 2'b00, 2'd0);
        rst = 1'b0;
        step("t6_after_reset", 0, 0, 2'b00, 2'd0);
        set_issue(1, 0, 5'd0, 3'd0);
        step("t6_issue_after_reset", 0, 1, 2'b00, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
